// File: rtl/pad_out_serializer.sv
// Buffers core result words (DEPTH deep) and shifts each out LANES bits per beat, LSB slice first.
// Latency: beat 0 is registered on the edge after the word is accepted; in_ready drops when DEPTH words are stored.
// Optional even beat parity on out_parity when PAD_SER_PARITY_EN is defined.
module pad_out_serializer #(
    parameter int DATA_W = 72,
    parameter int LANES  = 8,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [LANES-1:0]  out_data,
`ifdef PAD_SER_PARITY_EN
    output logic              out_parity,
`endif
    output logic              out_last
);

    localparam int BEATS  = (DATA_W + LANES - 1) / LANES;
    localparam int PAD_W  = BEATS * LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [BEAT_W-1:0]  beat;
    logic               push;
    logic               pop;
    logic               emit;
    logic [PAD_W-1:0]   head_pad;
    logic [LANES-1:0]   head_slice;

    // The word being shifted stays in the buffer until its last beat, so it
    // still occupies a slot and counts against in_ready.
    assign in_ready   = (count < DEPTH_C);
    assign push       = in_valid && in_ready;
    assign emit       = (count != '0);
    assign pop        = emit && (beat == LAST_BEAT);
    assign head_pad   = PAD_W'(mem[rd_ptr]);
    assign head_slice = head_pad[beat*LANES +: LANES];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            beat       <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
`ifdef PAD_SER_PARITY_EN
            out_parity <= 1'b0;
`endif
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            unique case (state)
                IDLE:  if (emit)  state <= SHIFT;
                SHIFT: if (!emit) state <= IDLE;
            endcase

            // The head word is consumed directly from the buffer, which is
            // what lets the next word start on the cycle after out_last.
            if (emit) begin
                out_valid  <= 1'b1;
                out_data   <= head_slice;
                out_last   <= pop;
`ifdef PAD_SER_PARITY_EN
                out_parity <= ^head_slice;
`endif
                beat       <= pop ? '0 : beat + BEAT_W'(1);
            end else begin
                out_valid  <= 1'b0;
                out_data   <= '0;
                out_last   <= 1'b0;
`ifdef PAD_SER_PARITY_EN
                out_parity <= 1'b0;
`endif
                beat       <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pad_out_serializer.sv
// Directed bench for pad_out_serializer: 72/8, 10/4 and 72/80 instances on one clock.
module tb_pad_out_serializer;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    logic        a_in_valid;
    logic [71:0] a_in_data;
    logic        a_in_ready;
    logic        a_out_valid;
    logic [7:0]  a_out_data;
    logic        a_out_last;

    logic        b_in_valid;
    logic [9:0]  b_in_data;
    logic        b_in_ready;
    logic        b_out_valid;
    logic [3:0]  b_out_data;
    logic        b_out_last;

    logic        c_in_valid;
    logic [71:0] c_in_data;
    logic        c_in_ready;
    logic        c_out_valid;
    logic [79:0] c_out_data;
    logic        c_out_last;

`ifdef PAD_SER_PARITY_EN
    logic a_out_parity;
    logic b_out_parity;
    logic c_out_parity;
`endif

    pad_out_serializer #(.DATA_W(72), .LANES(8), .DEPTH(2)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_data(a_in_data),
        .in_ready(a_in_ready), .out_valid(a_out_valid), .out_data(a_out_data),
`ifdef PAD_SER_PARITY_EN
        .out_parity(a_out_parity),
`endif
        .out_last(a_out_last)
    );

    pad_out_serializer #(.DATA_W(10), .LANES(4), .DEPTH(2)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_data(b_in_data),
        .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data),
`ifdef PAD_SER_PARITY_EN
        .out_parity(b_out_parity),
`endif
        .out_last(b_out_last)
    );

    pad_out_serializer #(.DATA_W(72), .LANES(80), .DEPTH(2)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_data(c_in_data),
        .in_ready(c_in_ready), .out_valid(c_out_valid), .out_data(c_out_data),
`ifdef PAD_SER_PARITY_EN
        .out_parity(c_out_parity),
`endif
        .out_last(c_out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [71:0] make_word(input int j);
        logic [71:0] w;
        for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'(16*j + k + 1);
        return w;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        a_in_valid = 1'b1;
        a_in_data  = 72'h112233445566778899;
        b_in_valid = 1'b0; b_in_data = '0;
        c_in_valid = 1'b0; c_in_data = '0;
        repeat (3) @(negedge clk);
        tests++;
        if ({a_out_valid, a_out_data, a_out_last, a_in_ready} !== {1'b0, 8'h00, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL reset_state: got v=%b d=%h l=%b rdy=%b, want v=0 d=00 l=0 rdy=1",
                     a_out_valid, a_out_data, a_out_last, a_in_ready);
        end
        rst = 1'b0;
        a_in_valid = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({a_out_valid, a_in_ready} !== 2'b01) begin
            fails++;
            $display("FAIL reset_no_capture: got v=%b rdy=%b, want v=0 rdy=1", a_out_valid, a_in_ready);
        end
    endtask

    task automatic test_basic72();
        logic [7:0] exp_d;
        a_in_valid = 1'b1;
        a_in_data  = 72'h090807060504030201;
        @(negedge clk);
        a_in_valid = 1'b0;
        tests++;
        if (a_out_valid !== 1'b0) begin
            fails++;
            $display("FAIL basic72_latency: out_valid=%b on accept cycle, want 0", a_out_valid);
        end
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            exp_d = 8'(k + 1);
            tests++;
            if ({a_out_valid, a_out_last, a_out_data} !== {1'b1, (k == 8), exp_d}) begin
                fails++;
                $display("FAIL basic72_beat%0d: got v=%b l=%b d=%h, want v=1 l=%b d=%h",
                         k, a_out_valid, a_out_last, a_out_data, (k == 8), exp_d);
            end
`ifdef PAD_SER_PARITY_EN
            tests++;
            if (a_out_parity !== ^exp_d) begin
                fails++;
                $display("FAIL parity_beat%0d: got %b want %b", k, a_out_parity, ^exp_d);
            end
`endif
        end
        @(negedge clk);
        tests++;
        if ({a_out_valid, a_out_last, a_out_data} !== 10'b0) begin
            fails++;
            $display("FAIL basic72_idle: got v=%b l=%b d=%h, want all 0", a_out_valid, a_out_last, a_out_data);
        end
`ifdef PAD_SER_PARITY_EN
        tests++;
        if (a_out_parity !== 1'b0) begin
            fails++;
            $display("FAIL parity_idle: got %b want 0", a_out_parity);
        end
`endif
    endtask

    task automatic test_odd_width();
        logic [3:0] exp_b [3];
        exp_b[0] = 4'hF; exp_b[1] = 4'hF; exp_b[2] = 4'h3;
        b_in_valid = 1'b1;
        b_in_data  = 10'h3FF;
        @(negedge clk);
        b_in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests++;
            if ({b_out_valid, b_out_last, b_out_data} !== {1'b1, (k == 2), exp_b[k]}) begin
                fails++;
                $display("FAIL odd_beat%0d: got v=%b l=%b d=%h, want v=1 l=%b d=%h",
                         k, b_out_valid, b_out_last, b_out_data, (k == 2), exp_b[k]);
            end
        end
        @(negedge clk);
        tests++;
        if (b_out_valid !== 1'b0) begin
            fails++;
            $display("FAIL odd_length: out_valid=%b after 3 beats, want 0", b_out_valid);
        end
    endtask

    task automatic test_wide_lanes();
        logic [79:0] exp_d;
        c_in_valid = 1'b1;
        c_in_data  = 72'hF1E2D3C4B5A6978869;
        exp_d      = {8'h00, 72'hF1E2D3C4B5A6978869};
        @(negedge clk);
        c_in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if ({c_out_valid, c_out_last, c_out_data} !== {1'b1, 1'b1, exp_d}) begin
            fails++;
            $display("FAIL wide_beat: got v=%b l=%b d=%h, want v=1 l=1 d=%h",
                     c_out_valid, c_out_last, c_out_data, exp_d);
        end
        @(negedge clk);
        tests++;
        if (c_out_valid !== 1'b0) begin
            fails++;
            $display("FAIL wide_single: out_valid=%b on second cycle, want 0", c_out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got_d [$];
        bit         got_l [$];
        int  pushed, blocked, first_c, last_c, bad_d, bad_l;
        logic rdy_prev;
        pushed = 0; blocked = 0; first_c = -1; last_c = -1; bad_d = 0; bad_l = 0;
        a_in_valid = 1'b1;
        a_in_data  = make_word(0);
        rdy_prev   = a_in_ready;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (a_in_valid && rdy_prev) pushed++;
            if (pushed == 3) a_in_valid = 1'b0;
            else             a_in_data  = make_word(pushed);
            if (a_in_valid && !a_in_ready) blocked++;
            rdy_prev = a_in_ready;
            if (a_out_valid) begin
                got_d.push_back(a_out_data);
                got_l.push_back(a_out_last);
                if (first_c < 0) first_c = c;
                last_c = c;
            end
        end
        a_in_valid = 1'b0;
        tests++;
        if (blocked !== 8) begin
            fails++;
            $display("FAIL b2b_blocked: third word blocked %0d cycles, want 8", blocked);
        end
        tests++;
        if (got_d.size() !== 27 || (last_c - first_c + 1) !== 27) begin
            fails++;
            $display("FAIL b2b_contiguous: beats=%0d span=%0d, want 27/27", got_d.size(), last_c - first_c + 1);
        end
        tests++;
        if (first_c !== 2) begin
            fails++;
            $display("FAIL b2b_first_beat: first beat at cycle %0d, want 2", first_c);
        end
        for (int i = 0; i < got_d.size() && i < 27; i++) begin
            if (got_d[i] !== 8'(16*(i/9) + (i%9) + 1)) bad_d++;
            if (got_l[i] !== ((i % 9) == 8)) bad_l++;
        end
        tests++;
        if (bad_d !== 0) begin
            fails++;
            $display("FAIL b2b_order: %0d beats with wrong data, want 0", bad_d);
        end
        tests++;
        if (bad_l !== 0) begin
            fails++;
            $display("FAIL b2b_last: %0d beats with wrong out_last, want 0", bad_l);
        end
    endtask

    task automatic test_reset_mid_word();
        int stray;
        stray = 0;
        a_in_valid = 1'b1;
        a_in_data  = make_word(0);
        @(negedge clk);
        a_in_data  = make_word(1);
        @(negedge clk);
        a_in_valid = 1'b0;
        repeat (4) @(negedge clk);
        tests++;
        if ({a_out_valid, a_out_data, a_in_ready} !== {1'b1, 8'h05, 1'b0}) begin
            fails++;
            $display("FAIL midrst_position: got v=%b d=%h rdy=%b, want v=1 d=05 rdy=0",
                     a_out_valid, a_out_data, a_in_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if ({a_out_valid, a_out_data, a_out_last, a_in_ready} !== {1'b0, 8'h00, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL midrst_outputs: got v=%b d=%h l=%b rdy=%b, want v=0 d=00 l=0 rdy=1",
                     a_out_valid, a_out_data, a_out_last, a_in_ready);
        end
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (a_out_valid !== 1'b0) stray++;
        end
        tests++;
        if (stray !== 0) begin
            fails++;
            $display("FAIL midrst_flush: %0d stray beats after reset, want 0", stray);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic72();
        test_odd_width();
        test_wide_lanes();
        test_back_to_back();
        test_reset_mid_word();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
